jk_excitation_sequencer: RTL

//  Inverse of the JK characteristic: given a programmed sequence of target states, derives
//  per-bit J/K excitation from the current state and drives a bank of edge-triggered JK bits
//  so the register walks the sequence, one target per clock. Used as a state-sequence

---
 rtl/jk_seq_pkg.sv | 24 ++
 rtl/jk_excitation_sequencer_jk_edge_ff.sv | 26 ++
 rtl/jk_excitation_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK excitation sequencer: FSM state codes,
// JK opcodes and the per-bit excitation function.
package jk_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // JK opcodes packed as {j,k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Inverse JK characteristic; don't-cares resolve to 0, so toggle is never issued.
    function automatic logic [1:0] excite(input logic q_bit, input logic t_bit);
        case ({q_bit, t_bit})
            2'b01:   return JK_SET;
            2'b10:   return JK_RST;
            default: return JK_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/jk_excitation_sequencer_jk_edge_ff.sv
// One rising-edge JK flip-flop bit with asynchronous active-high reset.
module jk_edge_ff
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_SET:  q <= 1'b1;
                JK_RST:  q <= 1'b0;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Walks a bank of JK bits through a programmed table of target states, one per clock.
// Optional build macro EXCIT_CHECK_EN adds a sticky checker that flags q != previous target.
module jk_excitation_sequencer
    import jk_seq_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    input  logic [AW:0]   start_len,
    input  logic          loop_en,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step_idx,
    output logic [W-1:0]  j_vec,
    output logic [W-1:0]  k_vec,
    output logic [W-1:0]  q,
    output logic          err
);

    logic [1:0]   state;
    logic [W-1:0] tbl [DEPTH];
    logic [AW:0]  len_r;
    logic         loop_r;
    logic [W-1:0] target;
    logic         start_ok;
    logic         last_step;

    assign start_ok  = start && (start_len != '0) && (start_len <= (AW+1)'(DEPTH));
    assign target    = tbl[step_idx];
    assign last_step = ({1'b0, step_idx} == (len_r - (AW+1)'(1)));
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    // NOTE: the target table is plain storage with no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && state == ST_IDLE) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            step_idx <= '0;
            len_r    <= '0;
            loop_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_RUN;
                        step_idx <= '0;
                        len_r    <= start_len;
                        loop_r   <= loop_en;
                    end
                end
                ST_RUN: begin
                    // stop wins over completion; the JK bits still take this cycle's step
                    if (stop) begin
                        state    <= ST_IDLE;
                        step_idx <= '0;
                    end else if (last_step) begin
                        step_idx <= '0;
                        if (!loop_r) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        step_idx <= step_idx + AW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (state == ST_RUN) begin
            for (int b = 0; b < W; b++) begin
                {j_vec[b], k_vec[b]} = excite(q[b], target[b]);
            end
        end
    end

    for (genvar b = 0; b < W; b++) begin : g_bit
        jk_edge_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[b]),
            .k   (k_vec[b]),
            .q   (q[b])
        );
    end

`ifdef EXCIT_CHECK_EN
    logic [W-1:0] prev_target;
    logic         first_cycle;
    logic         err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_target <= '0;
            first_cycle <= 1'b0;
            err_r       <= 1'b0;
        end else if (state == ST_IDLE && start_ok) begin
            first_cycle <= 1'b1;
            err_r       <= 1'b0;
        end else if (state == ST_RUN) begin
            first_cycle <= 1'b0;
            prev_target <= target;
            if (!first_cycle && q != prev_target) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
